// File: rtl/rv_bus_arbiter.sv
// rv_bus_arbiter: shares the single memory bus between instruction fetch and load/store.
// One transaction at a time; data has priority, and fetch is forced through after MAX_WAIT losses.
module rv_bus_arbiter #(
  parameter int IADDR_SPACE_BITS = 32,
  parameter int MAX_WAIT         = 4,
  parameter int TIMEOUT          = 255
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_instr_req,
  input  logic [IADDR_SPACE_BITS-1:1]   i_instr_addr,
  output logic                          o_instr_ack,
  output logic                          o_instr_err,
  output logic [31:0]                   o_instr_data,
  input  logic                          i_data_req,
  input  logic                          i_data_write,
  input  logic [31:0]                   i_data_addr,
  input  logic [3:0]                    i_data_sel,
  input  logic [31:0]                   i_data_wdata,
  output logic                          o_data_ack,
  output logic                          o_data_err,
  output logic [31:0]                   o_data_rdata,
  output logic                          o_bus_cyc,
  output logic                          o_bus_write,
  output logic [31:0]                   o_bus_addr,
  output logic [3:0]                    o_bus_sel,
  output logic [31:0]                   o_bus_wdata,
  input  logic                          i_bus_ack,
  input  logic [31:0]                   i_bus_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        bus_cyc_q, bus_cyc_d;
  logic        bus_write_q, bus_write_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        instr_ack_q, instr_ack_d;
  logic        instr_err_q, instr_err_d;
  logic [31:0] instr_data_q, instr_data_d;
  logic        data_ack_q, data_ack_d;
  logic        data_err_q, data_err_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic [31:0] fetch_addr_s;
  logic        timeout_s;
  logic        unused_addr_lsb_s;

  // Halfword fetch address becomes a zero-extended, word-aligned byte address.
  always_comb begin
    fetch_addr_s = 32'd0;
    fetch_addr_s[IADDR_SPACE_BITS-1:2] = i_instr_addr[IADDR_SPACE_BITS-1:2];
  end

  assign unused_addr_lsb_s = i_instr_addr[1];
  assign timeout_s = (TIMEOUT_C != 8'd0) && ((tmo_cnt_q + 8'd1) == TIMEOUT_C);

  // Next-state, arbitration and response logic.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = i_instr_req ? wait_cnt_q : 4'd0;
    tmo_cnt_d    = tmo_cnt_q;
    bus_cyc_d    = bus_cyc_q;
    bus_write_d  = bus_write_q;
    bus_addr_d   = bus_addr_q;
    bus_sel_d    = bus_sel_q;
    bus_wdata_d  = bus_wdata_q;
    instr_ack_d  = 1'b0;
    instr_err_d  = 1'b0;
    instr_data_d = instr_data_q;
    data_ack_d   = 1'b0;
    data_err_d   = 1'b0;
    data_rdata_d = data_rdata_q;
    case (state_q)
      IDLE: begin
        if (i_data_req && (!i_instr_req || (wait_cnt_q < MAX_WAIT_C))) begin
          state_d     = BUS_D;
          tmo_cnt_d   = 8'd0;
          bus_cyc_d   = 1'b1;
          bus_write_d = i_data_write;
          bus_addr_d  = i_data_addr;
          bus_sel_d   = i_data_sel;
          bus_wdata_d = i_data_wdata;
          if (i_instr_req) begin
            wait_cnt_d = (wait_cnt_q == 4'd15) ? 4'd15 : (wait_cnt_q + 4'd1);
          end else begin
            wait_cnt_d = 4'd0;
          end
        end else if (i_instr_req) begin
          state_d     = BUS_I;
          tmo_cnt_d   = 8'd0;
          wait_cnt_d  = 4'd0;
          bus_cyc_d   = 1'b1;
          bus_write_d = 1'b0;
          bus_addr_d  = fetch_addr_s;
          bus_sel_d   = 4'hF;
          bus_wdata_d = 32'd0;
        end else begin
          state_d = IDLE;
        end
      end
      BUS_I, BUS_D: begin
        // A slave ack in the final timeout cycle still counts as a success.
        if (i_bus_ack || timeout_s) begin
          state_d     = RESP;
          bus_cyc_d   = 1'b0;
          bus_write_d = 1'b0;
          if (state_q == BUS_I) begin
            instr_ack_d  = 1'b1;
            instr_err_d  = !i_bus_ack;
            instr_data_d = i_bus_ack ? i_bus_data : 32'd0;
          end else begin
            data_ack_d   = 1'b1;
            data_err_d   = !i_bus_ack;
            data_rdata_d = (i_bus_ack && !bus_write_q) ? i_bus_data : 32'd0;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 4'd0;
      tmo_cnt_q    <= 8'd0;
      bus_cyc_q    <= 1'b0;
      bus_write_q  <= 1'b0;
      bus_addr_q   <= 32'd0;
      bus_sel_q    <= 4'd0;
      bus_wdata_q  <= 32'd0;
      instr_ack_q  <= 1'b0;
      instr_err_q  <= 1'b0;
      instr_data_q <= 32'd0;
      data_ack_q   <= 1'b0;
      data_err_q   <= 1'b0;
      data_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      bus_cyc_q    <= bus_cyc_d;
      bus_write_q  <= bus_write_d;
      bus_addr_q   <= bus_addr_d;
      bus_sel_q    <= bus_sel_d;
      bus_wdata_q  <= bus_wdata_d;
      instr_ack_q  <= instr_ack_d;
      instr_err_q  <= instr_err_d;
      instr_data_q <= instr_data_d;
      data_ack_q   <= data_ack_d;
      data_err_q   <= data_err_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign o_instr_ack  = instr_ack_q;
  assign o_instr_err  = instr_err_q;
  assign o_instr_data = instr_data_q;
  assign o_data_ack   = data_ack_q;
  assign o_data_err   = data_err_q;
  assign o_data_rdata = data_rdata_q;
  assign o_bus_cyc    = bus_cyc_q;
  assign o_bus_write  = bus_write_q;
  assign o_bus_addr   = bus_addr_q;
  assign o_bus_sel    = bus_sel_q;
  assign o_bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_rv_bus_arbiter.sv
// tb_rv_bus_arbiter: directed and randomized checks of rv_bus_arbiter against a
// transaction-timeline model (grant cycle + slave delay -> bus window and response cycle).
module tb_rv_bus_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int TIMEOUT  = 8;

  logic        i_clk;
  logic        i_reset;
  logic        i_instr_req;
  logic [31:1] i_instr_addr;
  logic        o_instr_ack;
  logic        o_instr_err;
  logic [31:0] o_instr_data;
  logic        i_data_req;
  logic        i_data_write;
  logic [31:0] i_data_addr;
  logic [3:0]  i_data_sel;
  logic [31:0] i_data_wdata;
  logic        o_data_ack;
  logic        o_data_err;
  logic [31:0] o_data_rdata;
  logic        o_bus_cyc;
  logic        o_bus_write;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_sel;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ack;
  logic [31:0] i_bus_data;

  rv_bus_arbiter #(
    .IADDR_SPACE_BITS(32),
    .MAX_WAIT(MAX_WAIT),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_instr_req(i_instr_req), .i_instr_addr(i_instr_addr),
    .o_instr_ack(o_instr_ack), .o_instr_err(o_instr_err), .o_instr_data(o_instr_data),
    .i_data_req(i_data_req), .i_data_write(i_data_write), .i_data_addr(i_data_addr),
    .i_data_sel(i_data_sel), .i_data_wdata(i_data_wdata),
    .o_data_ack(o_data_ack), .o_data_err(o_data_err), .o_data_rdata(o_data_rdata),
    .o_bus_cyc(o_bus_cyc), .o_bus_write(o_bus_write), .o_bus_addr(o_bus_addr),
    .o_bus_sel(o_bus_sel), .o_bus_wdata(o_bus_wdata),
    .i_bus_ack(i_bus_ack), .i_bus_data(i_bus_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // Reference model: one outstanding transaction described by its timeline.
  int          cur_cycle = 0;
  bit          txn_active = 1'b0;
  bit          txn_is_data;
  int          txn_start, txn_len, txn_delay;
  bit          txn_err;
  logic [31:0] txn_rdata, exp_addr, exp_wdata, exp_resp;
  logic [3:0]  exp_sel;
  logic        exp_write;
  int          losses = 0;

  // Stimulus knobs
  int          p_fetch = 0, p_data = 0, spur_pct = 0, rst_pm = 0;
  int          d_min = 1, d_max = 1;
  bit          force_rdata_en = 1'b0;
  logic [31:0] force_rdata = 32'd0;
  bit          rst_req = 1'b0;

  // Observations
  int          iack_seen = 0, dack_seen = 0, iack_cyc = 0, dack_cyc = 0;
  logic        iack_err, dack_err;
  logic [31:0] iack_data, dack_data;
  int          cyc_run = 0, last_cyc_len = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    checks++;
    if (obs_v !== exp_v) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs_v, exp_v, cur_cycle);
    end
  endtask

  // One clock cycle: check outputs, drive requesters/slave, advance the model.
  task automatic step();
    bit          in_cyc, in_ack;
    logic [31:0] baddr;
    in_cyc = txn_active && (cur_cycle >= txn_start) && (cur_cycle < txn_start + txn_len);
    in_ack = txn_active && (cur_cycle == txn_start + txn_len);
    check_eq("bus_cyc", o_bus_cyc, in_cyc);
    check_eq("instr_ack", o_instr_ack, in_ack && !txn_is_data);
    check_eq("data_ack", o_data_ack, in_ack && txn_is_data);
    if (in_cyc) begin
      check_eq("bus_addr", o_bus_addr, exp_addr);
      check_eq("bus_sel", o_bus_sel, exp_sel);
      check_eq("bus_write", o_bus_write, exp_write);
      check_eq("bus_wdata", o_bus_wdata, exp_wdata);
    end
    if (in_ack && !txn_is_data) begin
      check_eq("instr_err", o_instr_err, txn_err);
      check_eq("instr_data", o_instr_data, exp_resp);
    end
    if (in_ack && txn_is_data) begin
      check_eq("data_err", o_data_err, txn_err);
      check_eq("data_rdata", o_data_rdata, exp_resp);
    end
    if (o_instr_ack) begin
      iack_seen++; iack_cyc = cur_cycle; iack_err = o_instr_err; iack_data = o_instr_data;
    end
    if (o_data_ack) begin
      dack_seen++; dack_cyc = cur_cycle; dack_err = o_data_err; dack_data = o_data_rdata;
    end
    if (o_bus_cyc) begin
      cyc_run++;
    end else begin
      if (cyc_run > 0) last_cyc_len = cyc_run;
      cyc_run = 0;
    end

    if (in_ack && !txn_is_data) i_instr_req = 1'b0;
    if (in_ack && txn_is_data) i_data_req = 1'b0;
    if (!i_instr_req && !(in_ack && !txn_is_data) && ($urandom % 100) < p_fetch) begin
      i_instr_req  = 1'b1;
      i_instr_addr = 31'($urandom);
    end
    if (!i_data_req && !(in_ack && txn_is_data) && ($urandom % 100) < p_data) begin
      i_data_req   = 1'b1;
      i_data_write = 1'($urandom);
      i_data_addr  = $urandom;
      i_data_sel   = 4'($urandom);
      i_data_wdata = $urandom;
    end

    if (in_cyc) begin
      i_bus_ack  = (cur_cycle == txn_start + txn_delay - 1);
      i_bus_data = txn_rdata;
    end else begin
      i_bus_ack  = ($urandom % 100) < spur_pct;
      i_bus_data = $urandom;
    end

    i_reset = rst_req || (($urandom % 1000) < rst_pm);
    rst_req = 1'b0;

    if (i_reset) begin
      txn_active = 1'b0;
      losses = 0;
    end else if (!txn_active || cur_cycle > txn_start + txn_len) begin
      txn_active = 1'b0;
      if (i_data_req && (!i_instr_req || losses < MAX_WAIT)) begin
        txn_is_data = 1'b1;
        exp_addr  = i_data_addr;
        exp_sel   = i_data_sel;
        exp_write = i_data_write;
        exp_wdata = i_data_wdata;
        txn_active = 1'b1;
        losses = i_instr_req ? ((losses >= 15) ? 15 : losses + 1) : 0;
      end else if (i_instr_req) begin
        txn_is_data = 1'b0;
        baddr     = {i_instr_addr, 1'b0};
        exp_addr  = baddr - (baddr % 32'd4);
        exp_sel   = 4'hF;
        exp_write = 1'b0;
        exp_wdata = 32'd0;
        txn_active = 1'b1;
        losses = 0;
      end else begin
        losses = 0;
      end
      if (txn_active) begin
        txn_start = cur_cycle + 1;
        txn_delay = int'($urandom_range(d_max, d_min));
        txn_err   = txn_delay > TIMEOUT;
        txn_len   = txn_err ? TIMEOUT : txn_delay;
        txn_rdata = force_rdata_en ? force_rdata : $urandom;
        exp_resp  = (txn_err || (txn_is_data && exp_write)) ? 32'd0 : txn_rdata;
      end
    end else if (!i_instr_req) begin
      losses = 0;
    end

    @(posedge i_clk);
    @(negedge i_clk);
    cur_cycle++;
  endtask

  task automatic run_until_iack(input int bound);
    int n0 = iack_seen;
    for (int i = 0; i < bound && iack_seen == n0; i++) step();
    check_eq("iack_within_bound", (iack_seen != n0), 1'b1);
  endtask

  task automatic run_until_dack(input int bound);
    int n0 = dack_seen;
    for (int i = 0; i < bound && dack_seen == n0; i++) step();
    check_eq("dack_within_bound", (dack_seen != n0), 1'b1);
  endtask

  task automatic drain();
    p_fetch = 0; p_data = 0; spur_pct = 0; rst_pm = 0;
    for (int i = 0; i < 80; i++) begin
      if (!i_instr_req && !i_data_req && (!txn_active || cur_cycle > txn_start + txn_len)) break;
      step();
    end
    check_eq("drain_idle", (i_instr_req || i_data_req), 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n0;
    i_reset = 1'b1; i_instr_req = 1'b0; i_instr_addr = 31'd0;
    i_data_req = 1'b0; i_data_write = 1'b0; i_data_addr = 32'd0;
    i_data_sel = 4'd0; i_data_wdata = 32'd0; i_bus_ack = 1'b0; i_bus_data = 32'd0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_eq("rst_bus_cyc", o_bus_cyc, 1'b0);
    check_eq("rst_bus_addr", o_bus_addr, 32'd0);
    check_eq("rst_bus_write", o_bus_write, 1'b0);
    check_eq("rst_instr_ack", o_instr_ack, 1'b0);
    check_eq("rst_data_ack", o_data_ack, 1'b0);
    check_eq("rst_data_rdata", o_data_rdata, 32'd0);

    // Fetch at halfword 'h81, slave acks in the third bus cycle with 'h13.
    drain();
    d_min = 3; d_max = 3; force_rdata_en = 1'b1; force_rdata = 32'h0000_0013;
    i_instr_req = 1'b1; i_instr_addr = 31'h81;
    c0 = cur_cycle;
    step();
    check_eq("fetch_cyc", o_bus_cyc, 1'b1);
    check_eq("fetch_addr", o_bus_addr, 32'h100);
    check_eq("fetch_sel", o_bus_sel, 4'hF);
    check_eq("fetch_write", o_bus_write, 1'b0);
    run_until_iack(20);
    check_eq("fetch_latency", iack_cyc - c0, 32'd4);
    check_eq("fetch_data", iack_data, 32'h13);
    check_eq("fetch_err", iack_err, 1'b0);

    // Store and fetch together: store first, fetch in the following IDLE.
    drain();
    d_min = 1; d_max = 1;
    i_data_req = 1'b1; i_data_write = 1'b1; i_data_addr = 32'h2000;
    i_data_sel = 4'h3; i_data_wdata = 32'hBEEF;
    i_instr_req = 1'b1; i_instr_addr = 31'h400;
    c0 = cur_cycle;
    step();
    check_eq("both_store_write", o_bus_write, 1'b1);
    check_eq("both_store_addr", o_bus_addr, 32'h2000);
    check_eq("both_store_sel", o_bus_sel, 4'h3);
    check_eq("both_store_wdata", o_bus_wdata, 32'hBEEF);
    repeat (3) step();
    check_eq("both_store_ack_cycle", dack_cyc - c0, 32'd2);
    check_eq("both_fetch_cyc", o_bus_cyc, 1'b1);
    check_eq("both_fetch_addr", o_bus_addr, 32'h800);
    run_until_iack(10);

    // Starvation guard: data re-requests back-to-back while fetch stays high.
    drain();
    n0 = dack_seen;
    i_instr_req = 1'b1; i_instr_addr = 31'h200;
    i_data_req = 1'b1; i_data_write = 1'b0; i_data_addr = 32'h3000; i_data_sel = 4'hF;
    p_data = 100;
    run_until_iack(80);
    check_eq("starve_data_wins", dack_seen - n0, 32'd4);
    drain();
    // Guard count restarts: data wins the next contended IDLE.
    i_instr_req = 1'b1; i_instr_addr = 31'h10;
    i_data_req = 1'b1; i_data_write = 1'b1; i_data_addr = 32'h44; i_data_sel = 4'h1;
    step();
    check_eq("wait_cleared_data_wins", o_bus_write, 1'b1);
    drain();

    // Load with no slave ack: timeout after TIMEOUT bus cycles.
    d_min = 20; d_max = 20;
    i_data_req = 1'b1; i_data_write = 1'b0; i_data_addr = 32'h5000; i_data_sel = 4'hF;
    run_until_dack(30);
    check_eq("tmo_cyc_len", last_cyc_len, TIMEOUT);
    check_eq("tmo_err", dack_err, 1'b1);
    check_eq("tmo_rdata", dack_data, 32'd0);

    // Reset while the bus is active drops the cycle without a response.
    drain();
    n0 = iack_seen;
    i_instr_req = 1'b1; i_instr_addr = 31'h40;
    repeat (2) step();
    check_eq("rst_mid_cyc_before", o_bus_cyc, 1'b1);
    rst_req = 1'b1; i_instr_req = 1'b0;
    step();
    check_eq("rst_mid_cyc_after", o_bus_cyc, 1'b0);
    repeat (3) step();
    check_eq("rst_mid_no_ack", iack_seen - n0, 32'd0);
    d_min = 2; d_max = 2; force_rdata = 32'hA5A5_0001;
    i_instr_req = 1'b1; i_instr_addr = 31'h123;
    run_until_iack(20);
    check_eq("rst_after_fetch_err", iack_err, 1'b0);
    check_eq("rst_after_fetch_data", iack_data, 32'hA5A5_0001);

    // Slave acks in IDLE and RESP must be ignored.
    drain();
    n0 = iack_seen;
    spur_pct = 100;
    i_instr_req = 1'b1; i_instr_addr = 31'h77;
    repeat (10) step();
    check_eq("spurious_single_ack", iack_seen - n0, 32'd1);
    drain();

    // Randomized traffic with varied slave delays, stray acks and resets.
    force_rdata_en = 1'b0;
    d_min = 1; d_max = TIMEOUT + 2;
    p_fetch = 35; p_data = 45; spur_pct = 20; rst_pm = 5;
    repeat (3000) step();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
